// File: rtl/commit_tracer.sv
// commit_tracer
//   Receiving end of the CPU commit port. Each retired instruction is checked
//   for PC continuity, counted, and its record {pc, instr, seq} is queued in a
//   show-ahead FIFO. A host drains the FIFO through a valid/ready handshake.
//   A halt request is raised on a PC mismatch, an ebreak, or when the step
//   limit is reached. The request then stays set until reset.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   commit                one instruction retires this cycle (no backpressure)
//   commit_instr/pc/pre_pc  retired instruction word, its PC, architectural next PC
//   step_limit            halt after this many commits (0 = unlimited)
//   trace_valid/ready     FIFO head handshake
//   trace_pc/instr/seq    head record (0 while the FIFO is empty)
//   instret               accepted commit count
//   halt, halt_cause      sticky halt request; 01 step, 10 ebreak, 11 PC mismatch
//   mismatch_pc           expected PC at the mismatch, 0 otherwise
//   overflow              sticky; a record was dropped on a full FIFO
//   done                  halted and FIFO fully drained
module commit_tracer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [31:0] commit_instr,
  input  logic [63:0] commit_pc,
  input  logic [63:0] commit_pre_pc,
  input  logic [63:0] step_limit,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [63:0] trace_pc,
  output logic [31:0] trace_instr,
  output logic [63:0] trace_seq,
  output logic [63:0] instret,
  output logic        halt,
  output logic [1:0]  halt_cause,
  output logic [63:0] mismatch_pc,
  output logic        overflow,
  output logic        done
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [31:0]   EBREAK   = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   instret_q, instret_d;
  logic [63:0]   expected_pc_q, expected_pc_d;
  logic          halt_q, halt_d;
  logic [1:0]    halt_cause_q, halt_cause_d;
  logic [63:0]   mismatch_pc_q, mismatch_pc_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [63:0] mem_pc    [DEPTH];
  logic [31:0] mem_instr [DEPTH];
  logic [63:0] mem_seq   [DEPTH];

  logic        accept;
  logic        pop;
  logic        push;
  logic [63:0] instret_inc;

  always_comb begin
    state_d       = state_q;
    instret_d     = instret_q;
    expected_pc_d = expected_pc_q;
    halt_d        = halt_q;
    halt_cause_d  = halt_cause_q;
    mismatch_pc_d = mismatch_pc_q;
    overflow_d    = overflow_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    accept      = commit && (state_q == S_RUN);
    pop         = (count_q != '0) && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the record.
    push        = accept && ((count_q != CNT_FULL) || pop);
    instret_inc = instret_q + 64'd1;

    if (accept) begin
      instret_d     = instret_inc;
      expected_pc_d = commit_pre_pc;
      if (!push) begin
        overflow_d = 1'b1;
      end
      if (commit_pc != expected_pc_q) begin
        halt_d        = 1'b1;
        halt_cause_d  = 2'b11;
        mismatch_pc_d = expected_pc_q;
        state_d       = S_DRAIN;
      end else if (commit_instr == EBREAK) begin
        halt_d       = 1'b1;
        halt_cause_d = 2'b10;
        state_d      = S_DRAIN;
      end else if ((step_limit != '0) && (instret_inc == step_limit)) begin
        halt_d       = 1'b1;
        halt_cause_d = 2'b01;
        state_d      = S_DRAIN;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Leave DRAIN on the edge where the last record is popped, so a single
    // remaining entry popped right after the halting commit finishes at once.
    if ((state_q == S_DRAIN) && (count_d == '0)) begin
      state_d = S_HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      instret_q     <= '0;
      expected_pc_q <= RESET_PC;
      halt_q        <= 1'b0;
      halt_cause_q  <= '0;
      mismatch_pc_q <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      instret_q     <= instret_d;
      expected_pc_q <= expected_pc_d;
      halt_q        <= halt_d;
      halt_cause_q  <= halt_cause_d;
      mismatch_pc_q <= mismatch_pc_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: the occupancy counter decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]    <= commit_pc;
      mem_instr[wr_ptr_q] <= commit_instr;
      mem_seq[wr_ptr_q]   <= instret_q;
    end
  end

  assign trace_valid = (count_q != '0);
  // Head fields are masked while empty so that stale entries never reach the host.
  assign trace_pc    = trace_valid ? mem_pc[rd_ptr_q]    : '0;
  assign trace_instr = trace_valid ? mem_instr[rd_ptr_q] : '0;
  assign trace_seq   = trace_valid ? mem_seq[rd_ptr_q]   : '0;
  assign instret     = instret_q;
  assign halt        = halt_q;
  assign halt_cause  = halt_cause_q;
  assign mismatch_pc = mismatch_pc_q;
  assign overflow    = overflow_q;
  assign done        = (state_q == S_HALTED);

endmodule

// File: tb/tb_commit_tracer.sv
// tb_commit_tracer
//   Drives directed scenarios and randomized commit streams into commit_tracer.
//   Every output is compared after each clock edge against a queue-based
//   reference model.
module tb_commit_tracer;

  localparam int unsigned DEPTH    = 8;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        commit;
  logic [31:0] commit_instr;
  logic [63:0] commit_pc;
  logic [63:0] commit_pre_pc;
  logic [63:0] step_limit;
  logic        trace_valid;
  logic        trace_ready;
  logic [63:0] trace_pc;
  logic [31:0] trace_instr;
  logic [63:0] trace_seq;
  logic [63:0] instret;
  logic        halt;
  logic [1:0]  halt_cause;
  logic [63:0] mismatch_pc;
  logic        overflow;
  logic        done;

  commit_tracer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit       (commit),
    .commit_instr (commit_instr),
    .commit_pc    (commit_pc),
    .commit_pre_pc(commit_pre_pc),
    .step_limit   (step_limit),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_pc     (trace_pc),
    .trace_instr  (trace_instr),
    .trace_seq    (trace_seq),
    .instret      (instret),
    .halt         (halt),
    .halt_cause   (halt_cause),
    .mismatch_pc  (mismatch_pc),
    .overflow     (overflow),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] seq;
  } rec_t;

  rec_t        mq[$];
  logic [63:0] m_instret;
  logic [63:0] m_exp;
  logic [63:0] m_mpc;
  logic        m_halt;
  logic        m_ovf;
  logic [1:0]  m_cause;
  int unsigned empty_run;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_instret = '0;
    m_exp     = RESET_PC;
    m_mpc     = '0;
    m_halt    = 1'b0;
    m_ovf     = 1'b0;
    m_cause   = 2'b00;
    empty_run = 0;
  endfunction

  task automatic check_outputs();
    check("trace_valid", trace_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("trace_pc", trace_pc, mq[0].pc);
      check("trace_instr", trace_instr, mq[0].instr);
      check("trace_seq", trace_seq, mq[0].seq);
    end else begin
      check("trace_pc_empty", trace_pc, 64'd0);
      check("trace_seq_empty", trace_seq, 64'd0);
    end
    check("instret", instret, m_instret);
    check("halt", halt, m_halt);
    check("halt_cause", halt_cause, m_cause);
    check("mismatch_pc", mismatch_pc, m_mpc);
    check("overflow", overflow, m_ovf);
    if (!m_halt || mq.size() > 0) check("done_low", done, 1'b0);
    else if (empty_run >= 2) check("done_high", done, 1'b1);
  endtask

  // One clock: update the model from the inputs now on the pins, then compare after the edge.
  task automatic tick();
    rec_t        r;
    logic [63:0] n;
    if (mq.size() > 0 && trace_ready) void'(mq.pop_front());
    if (commit && !m_halt) begin
      r.pc    = commit_pc;
      r.instr = commit_instr;
      r.seq   = m_instret;
      n       = m_instret + 64'd1;
      if (mq.size() < DEPTH) mq.push_back(r);
      else m_ovf = 1'b1;
      if (commit_pc != m_exp) begin
        m_halt = 1'b1; m_cause = 2'b11; m_mpc = m_exp;
      end else if (commit_instr == EBREAK) begin
        m_halt = 1'b1; m_cause = 2'b10;
      end else if (step_limit != 0 && n == step_limit) begin
        m_halt = 1'b1; m_cause = 2'b01;
      end
      m_exp     = commit_pre_pc;
      m_instret = n;
    end
    @(posedge clk);
    #1;
    empty_run = (mq.size() == 0) ? empty_run + 1 : 0;
    check_outputs();
  endtask

  task automatic drive(input logic c, input logic [63:0] pc, input logic [63:0] pre,
                       input logic [31:0] ins, input logic rdy);
    commit        = c;
    commit_pc     = pc;
    commit_pre_pc = pre;
    commit_instr  = ins;
    trace_ready   = rdy;
    tick();
  endtask

  // Called one time unit after a rising edge; reset pulses between edges.
  task automatic do_reset();
    commit = 1'b0;
    rst    = 1'b1;
    #2;
    rst    = 1'b0;
    model_reset();
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; commit = 1'b0; commit_instr = '0; commit_pc = '0; commit_pre_pc = '0;
    step_limit = '0; trace_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs();

    // Sequential stream
    step_limit = 0;
    for (int i = 0; i < 5; i++)
      drive(1'b1, RESET_PC + 64'(4*i), RESET_PC + 64'(4*i+4), NOP + 32'(i << 20), 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1);
    check("seq_instret", instret, 64'd5);
    check("seq_halt", halt, 1'b0);

    // Step limit: 4th commit ignored
    do_reset();
    step_limit = 3;
    for (int i = 0; i < 4; i++)
      drive(1'b1, RESET_PC + 64'(4*i), RESET_PC + 64'(4*i+4), NOP, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, '0, 1'b1);
    check("step_instret", instret, 64'd3);
    check("step_cause", halt_cause, 2'b01);
    check("step_done", done, 1'b1);

    // Jump then mismatch
    do_reset();
    step_limit = 0;
    drive(1'b1, 64'h8000_0000, 64'h8000_0100, NOP, 1'b1);
    drive(1'b1, 64'h8000_0100, 64'h8000_0104, NOP, 1'b1);
    check("jump_nohalt", halt, 1'b0);
    drive(1'b1, 64'h8000_0200, 64'h8000_0204, NOP, 1'b1);
    check("mism_cause", halt_cause, 2'b11);
    check("mism_pc", mismatch_pc, 64'h8000_0104);

    // Ebreak wins over a coincident step limit
    do_reset();
    step_limit = 2;
    drive(1'b1, RESET_PC, RESET_PC + 4, NOP, 1'b1);
    drive(1'b1, RESET_PC + 4, RESET_PC + 8, EBREAK, 1'b1);
    check("ebreak_cause", halt_cause, 2'b10);

    // Overflow: 10 commits into 8 slots, then drain
    do_reset();
    step_limit = 0;
    for (int i = 0; i < 10; i++)
      drive(1'b1, RESET_PC + 64'(4*i), RESET_PC + 64'(4*i+4), NOP, 1'b0);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_instret", instret, 64'd10);
    for (int i = 0; i < 9; i++) drive(1'b0, '0, '0, '0, 1'b1);
    check("ovf_drained", trace_valid, 1'b0);

    // Full FIFO with pop and push in the same cycle: nothing dropped
    do_reset();
    for (int i = 0; i < 8; i++)
      drive(1'b1, RESET_PC + 64'(4*i), RESET_PC + 64'(4*i+4), NOP, 1'b0);
    drive(1'b1, RESET_PC + 32, RESET_PC + 36, NOP, 1'b1);
    check("full_popush_ovf", overflow, 1'b0);
    for (int i = 0; i < 9; i++) drive(1'b0, '0, '0, '0, 1'b1);

    // Async reset mid-drain with 4 queued
    do_reset();
    step_limit = 4;
    for (int i = 0; i < 4; i++)
      drive(1'b1, RESET_PC + 64'(4*i), RESET_PC + 64'(4*i+4), NOP, 1'b0);
    check("pre_rst_halt", halt, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", trace_valid, 1'b0);
    check("arst_halt", halt, 1'b0);
    check("arst_instret", instret, 64'd0);
    check("arst_overflow", overflow, 1'b0);
    rst = 1'b0;
    model_reset();
    step_limit = 0;
    drive(1'b1, RESET_PC, RESET_PC + 4, NOP, 1'b1);
    check("post_rst_nohalt", halt, 1'b0);

    // Randomized streams
    for (int round = 0; round < 30; round++) begin
      int unsigned rp;
      logic [63:0] pc;
      logic [63:0] pre;
      do_reset();
      step_limit = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(1, 40));
      rp = $urandom_range(0, 4);
      for (int cyc = 0; cyc < 60; cyc++) begin
        pc  = ($urandom_range(0, 40) == 0) ? m_exp + 64'd8 : m_exp;
        pre = ($urandom_range(0, 5) == 0) ? {32'h0, $urandom} & 64'hffff_fffc : pc + 64'd4;
        drive($urandom_range(0, 3) != 0, pc, pre,
              ($urandom_range(0, 50) == 0) ? EBREAK : $urandom,
              $urandom_range(0, 3) < rp);
      end
      for (int cyc = 0; cyc < DEPTH + 2; cyc++) drive(1'b0, '0, '0, '0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
